mcycle_issue_scheduler: RTL and testbench
=========================================

MCYCLE_ISSUE_SCHEDULER -- requirements
Module: mcycle_issue_scheduler

Interface
REQ-001 Parameter NUM_THREADS, default 4, number of hardware threads competing for issue.
REQ-002 Parameter MC_LATENCY, default 5, cycles from multi-cycle issue to writeback.
REQ-003 Parameter SC_LATENCY, default 2, cycles from single-cycle issue to writeback; the module SHALL require SC_LATENCY < MC_LATENCY.
REQ-004 Port: clk, input, 1, clock.
REQ-005 Port: reset, input, 1, reset; one clock, reset is asynchronous and active-high.
REQ-006 Port: thread_req, input, NUM_THREADS, thread i has an instruction ready.
REQ-007 Port: thread_is_mcycle, input, NUM_THREADS, thread i's instruction targets the multi-cycle arithmetic pipeline.
REQ-008 Port: wb_rollback_en, input, 1, rollback strobe from writeback.
REQ-009 Port: wb_rollback_thread_idx, input, thread_idx_t, thread being rolled back.
REQ-010 Port: grant_oh, output, NUM_THREADS, one-hot issue grant, combinational.
REQ-011 Port: grant_valid, output, 1, OR of grant_oh.
REQ-012 Port: grant_thread_idx, output, thread_idx_t, encoded grant; 0 when grant_valid=0.
REQ-013 Port: mc_inflight_count, output, clog2(MC_LATENCY+1), registered count of live multi-cycle instructions.
REQ-014 Port: mc_busy, output, 1, mc_inflight_count != 0.

Function
REQ-015 The scheduler SHALL keep a reservation vector of MC_LATENCY slots, each a valid bit plus a thread_idx_t; slot k means writeback occurs k cycles from now.
REQ-016 Each clock, all slots SHALL shift down one position; slot 1 retires, slot 0 is unused.
REQ-017 A multi-cycle grant SHALL write slot MC_LATENCY valid with the granted thread; this slot is always free at grant time.
REQ-018 Thread i SHALL be eligible when thread_req[i]=1, it is not the thread being rolled back this cycle, and it is either multi-cycle or the slot SC_LATENCY (after this cycle's shift) is invalid.
REQ-019 Exactly one eligible thread SHALL be granted per cycle, round-robin; priority starts at the thread after the last granted thread.
REQ-020 The round-robin pointer SHALL advance only on a grant; with no eligible thread, grant_oh=0 and the pointer holds.
REQ-021 On wb_rollback_en, every valid slot tagged with wb_rollback_thread_idx SHALL be invalidated in the same clock edge as the shift; other threads' slots are unaffected.
REQ-022 mc_inflight_count SHALL equal the number of valid slots after each edge: +1 on a multi-cycle grant, -1 on a valid retire, minus slots cleared by rollback, all in one cycle.
REQ-023 A blocked single-cycle request SHALL NOT block other eligible threads (no head-of-line blocking).
REQ-024 Granting an ineligible thread, or more than one thread, SHALL never occur (assertion).

Reset
REQ-025 On reset: all slots invalid, mc_inflight_count=0, mc_busy=0, round-robin pointer selects thread 0 as highest priority.
REQ-026 During reset, grant_oh SHALL be 0; reset mid-operation discards all in-flight reservations with no retire side effects.

Structure
REQ-027 thread_idx_t and the latency constants SHALL come from the shared defines package; no new typedefs are introduced locally.
REQ-028 Round-robin selection SHALL be a separate sub-module rr_arbiter (request vector, update enable, one-hot grant) reusable by other issue logic.
REQ-029 Reservation vector and counter SHALL live in this module; no other state exists.

Verification
REQ-030 After reset, thread_req=4'b1111 and thread_is_mcycle=0 held for 4 cycles -> grants to threads 0,1,2,3 in order; mc_busy stays 0.
REQ-031 Thread 1 multi-cycle granted at cycle t, thread 2 single-cycle requesting continuously -> thread 2 blocked at t+3 (slot conflict), granted at t+4; count=1 from t+1 through t+5, then 0.
REQ-032 Thread 0 multi-cycle grants at t, t+1, t+2 -> mc_inflight_count reads 1,2,3 at t+1..t+3, and falls to 0 at t+8.
REQ-033 Threads 0 and 3 each hold 2 in-flight slots, rollback thread 3 -> count drops from 4 to 2 at the next edge (minus any retire); thread 0 slots still retire on schedule.
REQ-034 Rollback of thread 2 in the same cycle thread 2 is the only requester -> grant_valid=0; the pointer does not move.
REQ-035 Assert reset while count=3 -> count=0, all slots invalid immediately; the first grant after release goes to thread 0.

Source files
------------

// File: rtl/mcycle_issue_scheduler_pkg.sv
// Shared defines for the issue scheduler slice.
// Holds the default thread count and pipeline latencies, the thread index
// type used on every thread-indexed port, and the reservation slot record.
package mcycle_issue_scheduler_pkg;

    localparam int NUM_THREADS_DEF = 4;
    localparam int MC_LATENCY_DEF  = 5;
    localparam int SC_LATENCY_DEF  = 2;
    localparam int THREAD_IDX_W    = 2;

    typedef logic [THREAD_IDX_W-1:0] thread_idx_t;

    // One reservation slot: a multi-cycle writeback owned by a thread.
    typedef struct packed {
        logic        valid;
        thread_idx_t thread;
    } slot_t;

endpackage

// File: rtl/mcycle_issue_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter.
//   clk, reset  : clock, async active-high reset (thread 0 highest priority)
//   req         : request vector
//   update_en   : advance the priority pointer past the winner when set
//   grant_oh    : one-hot grant (combinational), zero when no request
// The pointer names the highest-priority requester; it moves to the
// position after the winner only when a grant is actually made.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         update_en,
    output logic [N-1:0] grant_oh
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] win;
    logic          found;

    always_comb begin
        grant_oh = '0;
        win      = '0;
        found    = 1'b0;
        for (int o = 0; o < N; o++) begin
            if (!found && req[(int'(ptr_q) + o) % N]) begin
                found                           = 1'b1;
                grant_oh[(int'(ptr_q) + o) % N] = 1'b1;
                win                             = IW'((int'(ptr_q) + o) % N);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr_q <= '0;
        else if (update_en && found)
            ptr_q <= (win == IW'(N - 1)) ? '0 : win + IW'(1);
    end

endmodule

// File: rtl/mcycle_issue_scheduler.sv
// mcycle_issue_scheduler: per-cycle thread issue with writeback-port
// reservation for a multi-cycle pipeline sharing writeback with a
// single-cycle one.
//   clk, reset              : clock, async active-high reset
//   thread_req              : per-thread instruction ready
//   thread_is_mcycle        : per-thread instruction is multi-cycle
//   wb_rollback_en/_idx     : squash a thread's in-flight multi-cycle ops
//   grant_oh/_valid/_idx    : combinational issue grant
//   mc_inflight_count/busy  : registered count of live reservations
// Slot k holds an op that writes back k cycles from now. A single-cycle op
// issued this cycle lands on the slot that will be SC_LATENCY after the
// shift, i.e. today's slot SC_LATENCY+1, so that slot gates eligibility.
module mcycle_issue_scheduler
    import mcycle_issue_scheduler_pkg::*;
#(
    parameter int NUM_THREADS = NUM_THREADS_DEF,
    parameter int MC_LATENCY  = MC_LATENCY_DEF,
    parameter int SC_LATENCY  = SC_LATENCY_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_THREADS-1:0]          thread_req,
    input  logic [NUM_THREADS-1:0]          thread_is_mcycle,
    input  logic                            wb_rollback_en,
    input  thread_idx_t                     wb_rollback_thread_idx,
    output logic [NUM_THREADS-1:0]          grant_oh,
    output logic                            grant_valid,
    output thread_idx_t                     grant_thread_idx,
    output logic [$clog2(MC_LATENCY+1)-1:0] mc_inflight_count,
    output logic                            mc_busy
);
    localparam int CNT_W = $clog2(MC_LATENCY + 1);

    if (SC_LATENCY < 1 || SC_LATENCY >= MC_LATENCY) begin : g_bad_latency
        $error("mcycle_issue_scheduler: need 1 <= SC_LATENCY < MC_LATENCY");
    end
    if (NUM_THREADS > (1 << THREAD_IDX_W)) begin : g_bad_threads
        $error("mcycle_issue_scheduler: NUM_THREADS exceeds thread_idx_t range");
    end

    slot_t [MC_LATENCY:1]   slot_q, slot_d;
    logic  [CNT_W-1:0]      cnt_d;
    logic  [NUM_THREADS-1:0] eligible, arb_grant;
    logic                   mc_grant;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            eligible[i] = thread_req[i]
                && !(wb_rollback_en && wb_rollback_thread_idx == thread_idx_t'(i))
                && (thread_is_mcycle[i] || !slot_q[SC_LATENCY+1].valid);
        end
    end

    rr_arbiter #(.N(NUM_THREADS)) u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (eligible),
        .update_en (!reset),
        .grant_oh  (arb_grant)
    );

    assign grant_oh    = reset ? '0 : arb_grant;
    assign grant_valid = |grant_oh;
    assign mc_grant    = |(grant_oh & thread_is_mcycle);

    always_comb begin
        grant_thread_idx = '0;
        for (int i = 0; i < NUM_THREADS; i++)
            if (grant_oh[i]) grant_thread_idx = grant_thread_idx | thread_idx_t'(i);
    end

    // Shift, insert the new reservation at the top, then squash the
    // rolled-back thread; the count is recomputed from the result so
    // grant, retire and rollback all net out in one edge.
    always_comb begin
        for (int k = 1; k < MC_LATENCY; k++)
            slot_d[k] = slot_q[k+1];
        slot_d[MC_LATENCY].valid  = mc_grant;
        slot_d[MC_LATENCY].thread = grant_thread_idx;
        cnt_d = '0;
        for (int k = 1; k <= MC_LATENCY; k++) begin
            if (wb_rollback_en && slot_d[k].thread == wb_rollback_thread_idx)
                slot_d[k].valid = 1'b0;
            if (slot_d[k].valid)
                cnt_d = cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q            <= '0;
            mc_inflight_count <= '0;
        end else begin
            slot_q            <= slot_d;
            mc_inflight_count <= cnt_d;
        end
    end

    assign mc_busy = |mc_inflight_count;

    a_grant_legal: assert property (@(posedge clk) disable iff (reset)
        $onehot0(grant_oh) && ((grant_oh & ~eligible) == '0));

endmodule

// File: tb/tb_mcycle_issue_scheduler.sv
// Bench for mcycle_issue_scheduler: directed scenarios plus random traffic
// against a model that tracks in-flight multi-cycle ops by grant cycle.
module tb_mcycle_issue_scheduler;
    import mcycle_issue_scheduler_pkg::*;

    localparam int NT = 4;
    localparam int MC = 5;
    localparam int SC = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [NT-1:0] thread_req, thread_is_mcycle;
    logic          wb_rollback_en;
    thread_idx_t   wb_rollback_thread_idx;
    logic [NT-1:0] grant_oh;
    logic          grant_valid;
    thread_idx_t   grant_thread_idx;
    logic [2:0]    mc_inflight_count;
    logic          mc_busy;

    mcycle_issue_scheduler #(.NUM_THREADS(NT), .MC_LATENCY(MC), .SC_LATENCY(SC)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .thread_req             (thread_req),
        .thread_is_mcycle       (thread_is_mcycle),
        .wb_rollback_en         (wb_rollback_en),
        .wb_rollback_thread_idx (wb_rollback_thread_idx),
        .grant_oh               (grant_oh),
        .grant_valid            (grant_valid),
        .grant_thread_idx       (grant_thread_idx),
        .mc_inflight_count      (mc_inflight_count),
        .mc_busy                (mc_busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Model: each multi-cycle op is remembered by thread and grant cycle.
    // It is live (counted) at cycle c when g < c <= g+MC; its writeback
    // falls at cycle g+MC, and a single-cycle op issued at c writes back at
    // c+SC, so those collide when g+MC == c+SC.
    typedef struct {int thr; int g;} op_t;
    op_t ops[$];
    int cyc, ptr, exp_thr, exp_cnt;
    logic [NT-1:0] cur_req, cur_mc;
    logic cur_rb;
    int cur_rbi;

    function automatic logic [10:0] exp_vec();
        logic [NT-1:0] oh;
        oh = '0;
        if (exp_thr >= 0) oh[exp_thr] = 1'b1;
        return {oh, thread_idx_t'(exp_thr < 0 ? 0 : exp_thr), exp_thr >= 0,
                3'(exp_cnt), exp_cnt != 0};
    endfunction

    function automatic logic [10:0] act_vec();
        return {grant_oh, grant_thread_idx, grant_valid, mc_inflight_count, mc_busy};
    endfunction

    function automatic int obs_thr();
        return grant_valid ? int'(grant_thread_idx) : -1;
    endfunction

    task automatic drive(input logic [NT-1:0] req, input logic [NT-1:0] mc,
                         input logic rb, input int rbi);
        bit conflict;
        thread_req = req; thread_is_mcycle = mc;
        wb_rollback_en = rb; wb_rollback_thread_idx = thread_idx_t'(rbi);
        cur_req = req; cur_mc = mc; cur_rb = rb; cur_rbi = rbi;
        exp_cnt = 0; conflict = 0;
        foreach (ops[k]) begin
            if (cyc <= ops[k].g + MC) exp_cnt++;
            if (ops[k].g + MC == cyc + SC) conflict = 1;
        end
        exp_thr = -1;
        for (int o = 0; o < NT; o++) begin
            int i;
            i = (ptr + o) % NT;
            if (exp_thr < 0 && req[i] && !(rb && rbi == i) && (mc[i] || !conflict))
                exp_thr = i;
        end
        #3;
    endtask

    task automatic tick();
        if (exp_thr >= 0) begin
            if (cur_mc[exp_thr]) ops.push_back('{exp_thr, cyc});
            ptr = (exp_thr + 1) % NT;
        end
        for (int k = ops.size() - 1; k >= 0; k--)
            if ((cur_rb && ops[k].thr == cur_rbi) || ops[k].g + MC <= cyc)
                ops.delete(k);
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        thread_req = '0; thread_is_mcycle = '0;
        wb_rollback_en = 1'b0; wb_rollback_thread_idx = '0;
        ops.delete(); ptr = 0; cyc = 0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        thread_req = '1; thread_is_mcycle = '1; wb_rollback_en = 1'b0;
        wb_rollback_thread_idx = '0;
        @(posedge clk); #1;
        n_total++;
        if (grant_oh !== 4'b0 || grant_valid !== 1'b0 || mc_inflight_count !== 3'd0 || mc_busy !== 1'b0)
            $display("FAIL reset: oh=%b v=%b cnt=%0d busy=%b, want 0", grant_oh, grant_valid, mc_inflight_count, mc_busy);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_rr_single();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(4'b1111, 4'b0000, 0, 0);
            n_total++;
            if (act_vec() !== exp_vec() || obs_thr() != i || mc_busy !== 1'b0)
                $display("FAIL rr_single c%0d: got %b thr %0d want %b thr %0d", i, act_vec(), obs_thr(), exp_vec(), i);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_mc_conflict();
        int eg[7] = '{1, 2, 2, -1, 2, 2, 2};
        int ec[7] = '{0, 1, 1, 1, 1, 1, 0};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            drive(c == 0 ? 4'b0110 : 4'b0100, c == 0 ? 4'b0010 : 4'b0000, 0, 0);
            n_total++;
            if (act_vec() !== exp_vec() || obs_thr() != eg[c] || int'(mc_inflight_count) != ec[c])
                $display("FAIL mc_conflict c%0d: got thr %0d cnt %0d want thr %0d cnt %0d", c, obs_thr(), mc_inflight_count, eg[c], ec[c]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_mc_count();
        int ec[9] = '{0, 1, 2, 3, 3, 3, 2, 1, 0};
        do_reset();
        for (int c = 0; c < 9; c++) begin
            drive(c < 3 ? 4'b0001 : 4'b0000, c < 3 ? 4'b0001 : 4'b0000, 0, 0);
            n_total++;
            if (act_vec() !== exp_vec() || int'(mc_inflight_count) != ec[c])
                $display("FAIL mc_count c%0d: got cnt %0d want %0d", c, mc_inflight_count, ec[c]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_rollback();
        int eg[9] = '{0, 3, 0, 3, -1, -1, -1, -1, -1};
        int ec[9] = '{0, 1, 2, 3, 4, 2, 1, 1, 0};
        do_reset();
        for (int c = 0; c < 9; c++) begin
            drive(c < 4 ? 4'b1001 : 4'b0000, c < 4 ? 4'b1001 : 4'b0000, c == 4, 3);
            n_total++;
            if (act_vec() !== exp_vec() || obs_thr() != eg[c] || int'(mc_inflight_count) != ec[c])
                $display("FAIL rollback c%0d: got thr %0d cnt %0d want thr %0d cnt %0d", c, obs_thr(), mc_inflight_count, eg[c], ec[c]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_rollback_only_req();
        int eg[3] = '{1, -1, 2};
        do_reset();
        for (int c = 0; c < 3; c++) begin
            case (c)
                0: drive(4'b0010, 4'b0000, 0, 0);
                1: drive(4'b0100, 4'b0000, 1, 2);
                default: drive(4'b1111, 4'b0000, 0, 0);
            endcase
            n_total++;
            if (act_vec() !== exp_vec() || obs_thr() != eg[c])
                $display("FAIL rollback_only c%0d: got thr %0d want %0d", c, obs_thr(), eg[c]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        for (int c = 0; c < 3; c++) begin drive(4'b0001, 4'b0001, 0, 0); tick(); end
        drive(4'b0000, 4'b0000, 0, 0);
        n_total++;
        if (mc_inflight_count !== 3'd3) $display("FAIL midop_pre: cnt %0d want 3", mc_inflight_count);
        else n_pass++;
        reset = 1'b1;
        thread_req = 4'b1111;
        #1;
        n_total++;
        if (mc_inflight_count !== 3'd0 || grant_oh !== 4'b0 || mc_busy !== 1'b0)
            $display("FAIL midop_reset: cnt %0d oh %b want 0 0", mc_inflight_count, grant_oh);
        else n_pass++;
        ops.delete(); ptr = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            drive(c == 0 ? 4'b1111 : 4'b0000, 4'b0000, 0, 0);
            n_total++;
            if (act_vec() !== exp_vec() || mc_inflight_count !== 3'd0 || (c == 0 && obs_thr() != 0))
                $display("FAIL midop_after c%0d: got %b want %b", c, act_vec(), exp_vec());
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive(4'($urandom), 4'($urandom & $urandom), ($urandom % 8) == 0, $urandom_range(0, NT - 1));
            n_total++;
            if (act_vec() !== exp_vec())
                $display("FAIL random c%0d: got %b want %b", c, act_vec(), exp_vec());
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_rr_single();
        test_mc_conflict();
        test_mc_count();
        test_rollback();
        test_rollback_only_req();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
